// File: rtl/encoder_32bit_scan.sv
// ---------------------------------------------------------------------------
// encoder_32bit_scan
//
// Accepts a 32-bit request word and emits one beat per set bit, lowest index
// first, over a valid/ready output handshake. An all-zero word produces a
// single beat flagged with out_zero. While the block is scanning a word it
// does not accept another one.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      synchronous reset, active low
//   in_valid   upstream word valid
//   in_data    request word, bit i = index i
//   in_ready   block is idle and can accept a word
//   out_valid  out_idx/out_zero/out_last/out_ord are valid
//   out_ready  downstream accepts the current beat
//   out_idx    binary index of the current set bit
//   out_zero   the accepted word was all zeros
//   out_last   final beat of the current word
//   out_ord    0-based ordinal of the beat within the word
// ---------------------------------------------------------------------------
module encoder_32bit_scan (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic        out_zero,
  output logic        out_last,
  output logic [5:0]  out_ord
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  // Mask of the word positions whose index has bit b set; drives one bit of
  // the one-hot to binary encoder.
  function automatic logic [31:0] pos_mask(input int b);
    logic [31:0] m;
    m = '0;
    for (int j = 0; j < 32; j++) begin
      m[j] = ((j >> b) & 1) == 1;
    end
    return m;
  endfunction

  logic [0:0]  state_reg;
  logic [31:0] word_reg;
  logic        out_valid_reg;
  logic [4:0]  out_idx_reg;
  logic        out_zero_reg;
  logic        out_last_reg;
  logic [5:0]  out_ord_reg;

  logic [31:0] word_cleared;
  logic [31:0] src_word;
  logic [31:0] lowest_onehot;
  logic [4:0]  enc_idx;
  logic        src_zero;
  logic        src_single;
  logic        beat_done;

  assign beat_done    = out_valid_reg & out_ready;

  // Remaining word once the bit currently on the output has been consumed.
  assign word_cleared = word_reg & ~(32'd1 << out_idx_reg);

  // One shared encoder: in IDLE it looks at the incoming word (first beat),
  // in SCAN at the remaining word (next beat). The result only feeds
  // registers, so there is no combinational in_* to out_* path.
  assign src_word      = (state_reg == IDLE) ? in_data : word_cleared;
  assign lowest_onehot = src_word & (~src_word + 32'd1);
  assign src_zero      = (src_word == 32'd0);
  // True for zero as well, which gives out_last=1 for the zero-word beat.
  assign src_single    = ((src_word & (src_word - 32'd1)) == 32'd0);

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_enc
      assign enc_idx[gi] = |(lowest_onehot & pos_mask(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      word_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
      out_zero_reg  <= 1'b0;
      out_last_reg  <= 1'b0;
      out_ord_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            state_reg     <= SCAN;
            word_reg      <= in_data;
            out_valid_reg <= 1'b1;
            out_idx_reg   <= enc_idx;
            out_zero_reg  <= src_zero;
            out_last_reg  <= src_single;
            out_ord_reg   <= '0;
          end
        end
        SCAN: begin
          if (beat_done) begin
            word_reg <= word_cleared;
            if (out_last_reg) begin
              state_reg     <= IDLE;
              out_valid_reg <= 1'b0;
              out_idx_reg   <= '0;
              out_zero_reg  <= 1'b0;
              out_last_reg  <= 1'b0;
              out_ord_reg   <= '0;
            end else begin
              out_idx_reg  <= enc_idx;
              out_last_reg <= src_single;
              out_ord_reg  <= out_ord_reg + 6'd1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign out_idx   = out_idx_reg;
  assign out_zero  = out_zero_reg;
  assign out_last  = out_last_reg;
  assign out_ord   = out_ord_reg;

endmodule

// File: tb/tb_encoder_32bit_scan.sv
// ---------------------------------------------------------------------------
// tb_encoder_32bit_scan
//
// Drives directed words and a randomized traffic phase into
// encoder_32bit_scan. A queue-based model holds the list of beats each
// accepted word must produce; every cycle the DUT outputs are compared
// against the head of that list. Directed words are additionally checked
// against hand-written expected beat lists.
// ---------------------------------------------------------------------------
module tb_encoder_32bit_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic        out_zero;
  logic        out_last;
  logic [5:0]  out_ord;

  always #5 clk = ~clk;

  encoder_32bit_scan dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_zero  (out_zero),
    .out_last  (out_last),
    .out_ord   (out_ord)
  );

  typedef struct {
    int idx;
    int zero;
    int last;
    int ord;
  } beat_t;

  beat_t model_q[$];
  beat_t log_q[$];
  int    exp_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    cmp_en = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an accepted word becomes its full list of beats.
  always @(posedge clk) begin
    int n;
    int k;
    if (!rst_n) begin
      model_q.delete();
    end else if (model_q.size() > 0) begin
      if (out_ready) void'(model_q.pop_front());
    end else if (in_valid) begin
      if (in_data == 32'd0) begin
        model_q.push_back('{idx: 0, zero: 1, last: 1, ord: 0});
      end else begin
        n = $countones(in_data);
        k = 0;
        for (int i = 0; i < 32; i++) begin
          if (in_data[i]) begin
            model_q.push_back('{idx: i, zero: 0, last: (k == n - 1) ? 1 : 0, ord: k});
            k++;
          end
        end
      end
    end
  end

  // Beat monitor: one line per completed beat.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      log_q.push_back('{idx: int'(out_idx), zero: int'(out_zero),
                        last: int'(out_last), ord: int'(out_ord)});
      $display("beat idx=%0d zero=%0d last=%0d ord=%0d t=%0t",
               out_idx, out_zero, out_last, out_ord, $time);
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready", int'(in_ready), (model_q.size() == 0) ? 1 : 0);
      chk("out_valid", int'(out_valid), (model_q.size() != 0) ? 1 : 0);
      if (model_q.size() != 0) begin
        chk("out_idx", int'(out_idx), model_q[0].idx);
        chk("out_zero", int'(out_zero), model_q[0].zero);
        chk("out_last", int'(out_last), model_q[0].last);
        chk("out_ord", int'(out_ord), model_q[0].ord);
      end
    end
  end

  // Present one word, then run until its last beat completes.
  // mode 0: out_ready=1; mode 1: out_ready toggles 1/0;
  // mode 2: out_ready=1 with random in_valid pulses during the scan.
  task automatic run_word(input logic [31:0] data, input int mode);
    int cyc;
    log_q.delete();
    in_data   = data;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!(log_q.size() > 0 && log_q[log_q.size() - 1].last == 1) && cyc < 200) begin
      if (mode == 1) out_ready = (cyc % 2 == 0);
      if (mode == 2) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = $urandom;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("word_timeout", (cyc < 200) ? 1 : 0, 1);
  endtask

  // Compare the logged beats with exp_q (indices in order).
  task automatic check_log(input string name, input int zero);
    int n;
    chk({name, "_beats"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({name, "_idx"}, log_q[i].idx, exp_q[i]);
      chk({name, "_ord"}, log_q[i].ord, i);
      chk({name, "_last"}, log_q[i].last, (i == exp_q.size() - 1) ? 1 : 0);
      chk({name, "_zero"}, log_q[i].zero, zero);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    cmp_en = 1'b1;

    // Reset state.
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_zero", int'(out_zero), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_ord", int'(out_ord), 0);

    // in_valid ignored while held in reset.
    in_valid = 1'b1;
    in_data  = 32'h0000_FFFF;
    tick();
    chk("rst_ignore_valid", int'(out_valid), 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();

    // Single-bit word.
    log_q.delete();
    in_data   = 32'h0001_0000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_busy", int'(in_ready), 0);
    chk("single_valid", int'(out_valid), 1);
    chk("single_idx_bit4", int'(out_idx[4]), 1);
    tick();
    chk("single_ready_again", int'(in_ready), 1);
    exp_q.delete();
    exp_q.push_back(16);
    check_log("single", 0);

    // Multi-bit word with toggling backpressure.
    run_word(32'h8000_0005, 1);
    exp_q.delete();
    exp_q.push_back(0);
    exp_q.push_back(2);
    exp_q.push_back(31);
    check_log("multi", 0);
    tick();
    chk("multi_idle", int'(in_ready), 1);

    // Zero word.
    run_word(32'h0000_0000, 0);
    exp_q.delete();
    exp_q.push_back(0);
    check_log("zero", 1);
    tick();
    chk("zero_idle", int'(in_ready), 1);

    // Full word with in_valid pulses during the scan.
    run_word(32'hFFFF_FFFF, 2);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(i);
    check_log("full", 0);
    tick();
    chk("full_idle", int'(in_ready), 1);

    // Reset in the middle of a scan.
    log_q.delete();
    in_data   = 32'h0000_F000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("midrst_beats", log_q.size(), 1);
    if (log_q.size() > 0) chk("midrst_idx", log_q[0].idx, 12);

    // Back-to-back words with in_valid held high.
    log_q.delete();
    in_data   = 32'h0000_0003;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_data = 32'h0000_0100;
    tick();
    tick();
    chk("b2b_idle_between", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("b2b_beats", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("b2b_idx0", log_q[0].idx, 0);
      chk("b2b_last0", log_q[0].last, 0);
      chk("b2b_idx1", log_q[1].idx, 1);
      chk("b2b_last1", log_q[1].last, 1);
      chk("b2b_ord1", log_q[1].ord, 1);
      chk("b2b_idx2", log_q[2].idx, 8);
      chk("b2b_last2", log_q[2].last, 1);
      chk("b2b_ord2", log_q[2].ord, 0);
    end

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0:       in_data = 32'd0;
        1:       in_data = 32'hFFFF_FFFF;
        2:       in_data = 32'd1 << $urandom_range(0, 31);
        3:       in_data = $urandom;
        default: in_data = $urandom & $urandom & $urandom;
      endcase
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/encoder_32bit_scan.md
ENCODER_32BIT_SCAN -- requirements
Module: encoder_32bit_scan

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, both defined in REQ-002 and REQ-003.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous reset, active low, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  upstream word valid.
REQ-005 in_data  input  32  request word; bit i corresponds to index i (bit 0 = index 0).
REQ-006 in_ready  output  1  block can accept a word.
REQ-007 out_valid  output  1  out_idx/out_zero/out_last/out_ord valid.
REQ-008 out_ready  input  1  downstream accepts the current beat.
REQ-009 out_idx  output  5  binary index of the current set bit.
REQ-010 out_zero  output  1  the accepted word was all zeros.
REQ-011 out_last  output  1  final beat of the current word.
REQ-012 out_ord  output  6  ordinal of the beat within the word, 0-based.

Function
REQ-013 Two states SHALL exist: IDLE and SCAN.
REQ-014 IDLE: in_ready=1, out_valid=0; on in_valid=1 the block SHALL capture in_data into an internal 32-bit register, clear out_ord, and enter SCAN on the same edge.
REQ-015 SCAN: in_ready=0; in_valid and in_data SHALL be ignored.
REQ-016 Latency SHALL be one cycle: out_valid=1 in the cycle immediately after the capture edge.
REQ-017 Beats SHALL be emitted lowest set index first; out_idx equals the position of the least-significant 1 in the remaining word.
REQ-018 A beat completes only on a clock edge where out_valid=1 and out_ready=1; on completion the bit at out_idx SHALL be cleared and out_ord incremented.
REQ-019 While out_ready=0, out_valid, out_idx, out_zero, out_last and out_ord SHALL hold stable.
REQ-020 out_last=1 exactly when the remaining word has one set bit, or when out_zero=1.
REQ-021 When the captured word is 0x00000000, exactly one beat SHALL be emitted with out_zero=1, out_idx=0, out_last=1 and out_ord=0.
REQ-022 Any nonzero word SHALL produce exactly popcount(word) beats, with out_zero=0 and out_ord running 0..popcount-1.
REQ-023 On the edge completing a beat with out_last=1, the block SHALL return to IDLE; in_ready=1 in the next cycle, which gives a minimum of 2 cycles per single-bit word.
REQ-024 A word with all 32 bits set SHALL produce 32 beats, indices 0..31, with the last beat showing out_ord=31 and out_idx=31.
REQ-025 The index for index bit 4 SHALL match the 1-cycle encoder convention: out_idx[4]=1 iff the emitted bit is in positions 16..31.
REQ-026 All outputs SHALL be driven directly from registers or from the state register only, with no combinational path from in_* to out_*.

Reset
REQ-027 On a rising edge with rst_n=0, the block SHALL set state=IDLE, the word register to 0, out_valid=0, out_idx=0, out_zero=0, out_last=0 and out_ord=0; in_ready=1 from the first cycle after the reset edge.
REQ-028 If reset is asserted during SCAN, the word in progress SHALL be discarded and no further beats SHALL be emitted for it.
REQ-029 While rst_n=0, in_valid SHALL be ignored.

Verification
REQ-030 Single-bit word: in_data=0x00010000, out_ready=1 -> one beat with out_idx=16, out_last=1, out_ord=0; in_ready=1 two cycles after the capture edge.
REQ-031 Multi-bit word with backpressure: in_data=0x80000005, out_ready toggling 1/0 -> beats with idx 0, 2, 31 and ord 0, 1, 2, last only on idx 31; outputs stable while out_ready=0.
REQ-032 Zero word: in_data=0x00000000 -> one beat with out_zero=1, out_idx=0, out_last=1; then return to IDLE.
REQ-033 Full word: in_data=0xFFFFFFFF, out_ready=1 -> 32 consecutive beats with idx 0..31, last on beat 32; in_valid pulses during SCAN are ignored.
REQ-034 Reset mid-scan: in_data=0x0000F000, rst_n=0 after the first beat -> out_valid=0 the next cycle, in_ready=1, and no idx 13..15 beats appear.
REQ-035 Back-to-back words: 0x00000003 then 0x00000100 with in_valid held high -> beats 0, 1(last), 8(last); the second word is captured on the first IDLE cycle.
